// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: buffers dispatched ops, snoops both CDBs
// for operand wakeup and issues the lowest-index ready op as a one-cycle execute pulse.
module alu_rs #(
  parameter int RS_SIZE = 8,
  parameter int OP_W    = 7,
  parameter int VAL_W   = 32,
  parameter int ID_W    = 4
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear_in,
  input  logic             dispatch_valid,
  input  logic [OP_W-1:0]  dispatch_type,
  input  logic [VAL_W-1:0] dispatch_vj,
  input  logic [VAL_W-1:0] dispatch_vk,
  input  logic             dispatch_qj_busy,
  input  logic [ID_W-1:0]  dispatch_qj,
  input  logic             dispatch_qk_busy,
  input  logic [ID_W-1:0]  dispatch_qk,
  input  logic [ID_W-1:0]  dispatch_entry,
  input  logic             alu_cdb_valid,
  input  logic [ID_W-1:0]  alu_cdb_entry,
  input  logic [VAL_W-1:0] alu_cdb_val,
  input  logic             lsb_cdb_valid,
  input  logic [ID_W-1:0]  lsb_cdb_entry,
  input  logic [VAL_W-1:0] lsb_cdb_val,
  output logic             rs_full,
  output logic             execute,
  output logic [OP_W-1:0]  op_type,
  output logic [VAL_W-1:0] val1,
  output logic [VAL_W-1:0] val2,
  output logic [ID_W-1:0]  entry
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic             busy_r    [RS_SIZE];
  logic [OP_W-1:0]  type_r    [RS_SIZE];
  logic [VAL_W-1:0] vj_r      [RS_SIZE];
  logic [VAL_W-1:0] vk_r      [RS_SIZE];
  logic             qj_busy_r [RS_SIZE];
  logic [ID_W-1:0]  qj_r      [RS_SIZE];
  logic             qk_busy_r [RS_SIZE];
  logic [ID_W-1:0]  qk_r      [RS_SIZE];
  logic [ID_W-1:0]  entry_r   [RS_SIZE];

  logic [VAL_W:0]   wj_s [RS_SIZE];
  logic [VAL_W:0]   wk_s [RS_SIZE];
  logic             free_found_s;
  logic [IDX_W-1:0] free_idx_s;
  logic             issue_found_s;
  logic [IDX_W-1:0] issue_idx_s;

  // Returns {still_pending, value}; the ALU bus wins when both buses carry the tag.
  function automatic logic [VAL_W:0] resolve(input logic pend, input logic [ID_W-1:0] tag,
                                             input logic [VAL_W-1:0] val);
    logic [VAL_W:0] res;
    if (pend && alu_cdb_valid && (tag == alu_cdb_entry)) begin
      res = {1'b0, alu_cdb_val};
    end else if (pend && lsb_cdb_valid && (tag == lsb_cdb_entry)) begin
      res = {1'b0, lsb_cdb_val};
    end else begin
      res = {pend, val};
    end
    return res;
  endfunction

  // Lowest-index free slot and lowest-index ready slot, from cycle-start state.
  always_comb begin
    free_found_s  = 1'b0;
    free_idx_s    = '0;
    issue_found_s = 1'b0;
    issue_idx_s   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_r[i]) begin
        free_found_s = 1'b1;
        free_idx_s   = IDX_W'(i);
      end else if (!qj_busy_r[i] && !qk_busy_r[i]) begin
        issue_found_s = 1'b1;
        issue_idx_s   = IDX_W'(i);
      end else begin
      end
    end
  end

  // Operand wakeup candidates for every slot.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      wj_s[i] = resolve(qj_busy_r[i], qj_r[i], vj_r[i]);
      wk_s[i] = resolve(qk_busy_r[i], qk_r[i], vk_r[i]);
    end
  end

  assign rs_full = ~free_found_s;

  // Slot state and registered issue port.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        busy_r[i]    <= 1'b0;
        type_r[i]    <= '0;
        vj_r[i]      <= '0;
        vk_r[i]      <= '0;
        qj_busy_r[i] <= 1'b0;
        qj_r[i]      <= '0;
        qk_busy_r[i] <= 1'b0;
        qk_r[i]      <= '0;
        entry_r[i]   <= '0;
      end
      execute <= 1'b0;
      op_type <= '0;
      val1    <= '0;
      val2    <= '0;
      entry   <= '0;
    end else if (clear_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        busy_r[i] <= 1'b0;
      end
      execute <= 1'b0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_r[i]) begin
          {qj_busy_r[i], vj_r[i]} <= wj_s[i];
          {qk_busy_r[i], vk_r[i]} <= wk_s[i];
        end
      end
      if (issue_found_s) begin
        execute             <= 1'b1;
        op_type             <= type_r[issue_idx_s];
        val1                <= vj_r[issue_idx_s];
        val2                <= vk_r[issue_idx_s];
        entry               <= entry_r[issue_idx_s];
        busy_r[issue_idx_s] <= 1'b0;
      end else begin
        execute <= 1'b0;
      end
      // The free slot is never the issuing slot, so these writes cannot collide.
      if (dispatch_valid && free_found_s) begin
        busy_r[free_idx_s]                       <= 1'b1;
        type_r[free_idx_s]                       <= dispatch_type;
        {qj_busy_r[free_idx_s], vj_r[free_idx_s]} <= resolve(dispatch_qj_busy, dispatch_qj, dispatch_vj);
        {qk_busy_r[free_idx_s], vk_r[free_idx_s]} <= resolve(dispatch_qk_busy, dispatch_qk, dispatch_vk);
        qj_r[free_idx_s]                         <= dispatch_qj;
        qk_r[free_idx_s]                         <= dispatch_qk;
        entry_r[free_idx_s]                      <= dispatch_entry;
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: expected issues (with due cycle) are queued at stimulus
// time and compared whenever execute is seen.
module tb_alu_rs;
  logic        clk = 1'b0;
  logic        rst_in, rdy_in, clear_in, dispatch_valid;
  logic [6:0]  dispatch_type;
  logic [31:0] dispatch_vj, dispatch_vk;
  logic        dispatch_qj_busy, dispatch_qk_busy;
  logic [3:0]  dispatch_qj, dispatch_qk, dispatch_entry;
  logic        alu_cdb_valid, lsb_cdb_valid;
  logic [3:0]  alu_cdb_entry, lsb_cdb_entry;
  logic [31:0] alu_cdb_val, lsb_cdb_val;
  logic        rs_full, execute;
  logic [6:0]  op_type;
  logic [31:0] val1, val2;
  logic [3:0]  entry;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [106:0] exp_q [$];

  alu_rs dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .dispatch_valid(dispatch_valid), .dispatch_type(dispatch_type),
    .dispatch_vj(dispatch_vj), .dispatch_vk(dispatch_vk),
    .dispatch_qj_busy(dispatch_qj_busy), .dispatch_qj(dispatch_qj),
    .dispatch_qk_busy(dispatch_qk_busy), .dispatch_qk(dispatch_qk),
    .dispatch_entry(dispatch_entry),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_entry(alu_cdb_entry), .alu_cdb_val(alu_cdb_val),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_entry(lsb_cdb_entry), .lsb_cdb_val(lsb_cdb_val),
    .rs_full(rs_full), .execute(execute), .op_type(op_type),
    .val1(val1), .val2(val2), .entry(entry)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every execute pulse must match the oldest expected issue, including its cycle.
  always @(negedge clk) begin
    if (!rst_in && execute) begin
      if (exp_q.size() == 0) chk("spurious_issue", {cyc, op_type, val1, val2, entry}, 128'd0);
      else chk("issue", {cyc, op_type, val1, val2, entry}, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    dispatch_valid = 1'b0; alu_cdb_valid = 1'b0; lsb_cdb_valid = 1'b0; clear_in = 1'b0;
  endtask

  task automatic disp(input logic [6:0] t, input logic [31:0] vj, input logic [31:0] vk,
                      input logic qjb, input logic [3:0] qj, input logic qkb,
                      input logic [3:0] qk, input logic [3:0] e);
    dispatch_valid = 1'b1; dispatch_type = t; dispatch_vj = vj; dispatch_vk = vk;
    dispatch_qj_busy = qjb; dispatch_qj = qj; dispatch_qk_busy = qkb; dispatch_qk = qk;
    dispatch_entry = e;
  endtask

  task automatic push(input int d, input logic [6:0] t, input logic [31:0] v1,
                      input logic [31:0] v2, input logic [3:0] e);
    int due;
    due = cyc + d;
    exp_q.push_back({due, t, v1, v2, e});
  endtask

  task automatic alu(input logic [3:0] e, input logic [31:0] v);
    alu_cdb_valid = 1'b1; alu_cdb_entry = e; alu_cdb_val = v;
  endtask

  task automatic lsb(input logic [3:0] e, input logic [31:0] v);
    lsb_cdb_valid = 1'b1; lsb_cdb_entry = e; lsb_cdb_val = v;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0; dispatch_valid = 1'b0;
    dispatch_type = 7'd0; dispatch_vj = 32'd0; dispatch_vk = 32'd0;
    dispatch_qj_busy = 1'b0; dispatch_qj = 4'd0; dispatch_qk_busy = 1'b0; dispatch_qk = 4'd0;
    dispatch_entry = 4'd0; alu_cdb_valid = 1'b0; alu_cdb_entry = 4'd0; alu_cdb_val = 32'd0;
    lsb_cdb_valid = 1'b0; lsb_cdb_entry = 4'd0; lsb_cdb_val = 32'd0;
    tick(); tick();
    rst_in = 1'b0;
    chk("rst_execute", execute, 1'b0);
    chk("rst_full", rs_full, 1'b0);
    chk("rst_outs", {op_type, val1, val2, entry}, 75'd0);

    // Resolved add issues two cycles after dispatch.
    disp(7'h01, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3); push(2, 7'h01, 32'd5, 32'd7, 4'd3);
    repeat (4) tick();

    // Wakeup via ALU CDB three cycles after dispatch.
    disp(7'h02, 32'd0, 32'd9, 1'b1, 4'd2, 1'b0, 4'd0, 4'd4);
    repeat (3) tick();
    alu(4'd2, 32'h10); push(2, 7'h02, 32'h10, 32'd9, 4'd4);
    repeat (3) tick();

    // Dispatch bypass from the LSB CDB.
    disp(7'h23, 32'd0, 32'h33, 1'b1, 4'd4, 1'b0, 4'd0, 4'd5); lsb(4'd4, 32'hAB);
    push(2, 7'h23, 32'hAB, 32'h33, 4'd5);
    repeat (3) tick();

    // Same tag on both buses: ALU value wins for both operands.
    disp(7'h44, 32'd0, 32'd0, 1'b1, 4'd6, 1'b1, 4'd6, 4'd7); tick();
    alu(4'd6, 32'h111); lsb(4'd6, 32'h222); push(2, 7'h44, 32'h111, 32'h111, 4'd7);
    repeat (3) tick();

    // Two operands woken by different buses in one cycle.
    disp(7'h45, 32'd0, 32'd0, 1'b1, 4'd1, 1'b1, 4'd2, 4'd8); tick();
    alu(4'd1, 32'hA); lsb(4'd2, 32'hB); push(2, 7'h45, 32'hA, 32'hB, 4'd8);
    repeat (3) tick();

    // Fill with blocked ops; the overflow dispatch must be dropped.
    for (int i = 0; i < 8; i++) begin
      disp(7'h10 + 7'(i), 32'd0, 32'h100 + 32'(i), 1'b1, 4'(8 + i), 1'b0, 4'd0, 4'(i));
      tick();
    end
    chk("full_after_fill", rs_full, 1'b1);
    disp(7'h7F, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15); tick();
    chk("full_after_drop", rs_full, 1'b1);
    alu(4'd13, 32'h55); push(2, 7'h15, 32'h55, 32'h105, 4'd5); tick();
    chk("full_wake_cycle", rs_full, 1'b1);
    tick();
    chk("full_after_issue", rs_full, 1'b0);
    disp(7'h66, 32'h6, 32'h66, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9); push(2, 7'h66, 32'h6, 32'h66, 4'd9);
    tick();
    chk("full_reused", rs_full, 1'b1);
    tick();
    chk("full_reissued", rs_full, 1'b0);

    // Flush: slot 0 ready and a ready dispatch in the clear cycle must both vanish.
    alu(4'd8, 32'h77); tick();
    clear_in = 1'b1; disp(7'h70, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd10); tick();
    chk("clear_execute", execute, 1'b0);
    chk("clear_full", rs_full, 1'b0);
    for (int t = 9; t < 16; t++) begin
      alu(4'(t), 32'hDEAD); tick();
    end
    repeat (2) tick();

    // Priority: slots 1 and 5 ready together issue back to back, lower index first.
    for (int i = 0; i < 6; i++) begin
      disp(7'h30 + 7'(i), 32'd0, 32'h200 + 32'(i), 1'b1, 4'(8 + i), 1'b0, 4'd0, 4'(i));
      tick();
    end
    alu(4'd9, 32'hC1); lsb(4'd13, 32'hC5);
    push(2, 7'h31, 32'hC1, 32'h201, 4'd1); push(3, 7'h35, 32'hC5, 32'h205, 4'd5);
    repeat (4) tick();
    clear_in = 1'b1; tick();

    // Stall: state and outputs frozen, dispatch ignored while rdy_in=0.
    disp(7'h50, 32'h5A, 32'h5B, 1'b0, 4'd0, 1'b0, 4'd0, 4'd12); tick();
    rdy_in = 1'b0;
    disp(7'h51, 32'h1, 32'h2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd13); tick();
    chk("stall_execute", execute, 1'b0);
    chk("stall_hold", {val1, entry}, {32'hC5, 4'd5});
    tick(); tick();
    chk("stall_hold_late", {execute, val1, entry}, {1'b0, 32'hC5, 4'd5});
    rdy_in = 1'b1; push(1, 7'h50, 32'h5A, 32'h5B, 4'd12);
    repeat (4) tick();

    chk("drain", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
